// File: rtl/complete_arbiter.sv
// Completion arbiter: per-unit skid FIFOs (ALU, BRU, MEM) merged round-robin
// into one completion per cycle. msg layout: [42:35] commit_id, [34] kind, [33:0] content.
module complete_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int N_CH       = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flash,
  input  logic        alu_result_en,
  input  logic [42:0] alu_result_msg,
  output logic        alu_result_reject,
  input  logic        bru_result_en,
  input  logic [42:0] bru_result_msg,
  output logic        bru_result_reject,
  input  logic        mem_result_en,
  input  logic [42:0] mem_result_msg,
  output logic        mem_result_reject,
  output logic        complete_info_en,
  output logic [42:0] complete_info_msg,
  input  logic        complete_info_reject,
  output logic        busy
);

  localparam int MSG_W = 43;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CH_W  = 2;

  logic [N_CH-1:0]            in_en;
  logic [N_CH-1:0][MSG_W-1:0] in_msg;
  logic [N_CH-1:0]            full;
  logic [N_CH-1:0]            not_empty;
  logic [N_CH-1:0]            pop;
  logic [N_CH-1:0][MSG_W-1:0] head_msg;

  logic [CH_W-1:0] rr_ptr_reg;
  logic [CH_W-1:0] rr_ptr_next;
  logic [CH_W-1:0] grant;
  logic            grant_valid;
  logic            out_fire;

  assign in_en  = {mem_result_en, bru_result_en, alu_result_en};
  assign in_msg = {mem_result_msg, bru_result_msg, alu_result_msg};

  // Rejects come straight from the registered counts, so downstream
  // backpressure never reaches the producers combinationally.
  assign alu_result_reject = full[0];
  assign bru_result_reject = full[1];
  assign mem_result_reject = full[2];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [MSG_W-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0] rd_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_next;
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] wr_ptr_next;
      logic [CNT_W-1:0] count_reg;
      logic [CNT_W-1:0] count_next;
      logic             push;

      assign full[gi]      = (count_reg == CNT_W'(FIFO_DEPTH));
      assign not_empty[gi] = (count_reg != '0);
      assign push          = in_en[gi] & ~full[gi] & ~flash;
      assign head_msg[gi]  = mem[rd_ptr_reg];

      always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flash) begin
          rd_ptr_next = '0;
          wr_ptr_next = '0;
          count_next  = '0;
        end else begin
          if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
          end
          if (pop[gi]) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
          end
          if (push && !pop[gi]) begin
            count_next = count_reg + 1'b1;
          end else if (!push && pop[gi]) begin
            count_next = count_reg - 1'b1;
          end
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          rd_ptr_reg <= rd_ptr_next;
          wr_ptr_reg <= wr_ptr_next;
          count_reg  <= count_next;
        end
      end

      // Payload storage needs no reset; validity is tracked by count alone.
      always_ff @(posedge clock) begin
        if (push) begin
          mem[wr_ptr_reg] <= in_msg[gi];
        end
      end
    end
  endgenerate

  // First non-empty channel in the order rr_ptr, rr_ptr+1, rr_ptr+2; the
  // descending scan lets the nearest candidate overwrite farther ones.
  always_comb begin
    int cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant       = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      if (not_empty[cand]) begin
        grant_valid = 1'b1;
        grant       = CH_W'(cand);
      end
    end
  end

  assign out_fire = grant_valid & ~complete_info_reject;
  assign pop      = {{(N_CH - 1){1'b0}}, out_fire} << grant;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (flash) begin
      rr_ptr_next = '0;
    end else if (out_fire) begin
      rr_ptr_next = (grant == CH_W'(N_CH - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign complete_info_en  = grant_valid;
  assign complete_info_msg = head_msg[grant];
  assign busy              = |not_empty;

endmodule

// File: tb/tb_complete_arbiter.sv
// Randomized bench for complete_arbiter against a queue-based reference model,
// with directed scenarios for latency, fairness, backpressure, flash and async reset.
module tb_complete_arbiter;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flash = 1'b0;
  logic        in_en [3];
  logic [42:0] in_msg [3];
  logic        rej [3];
  logic        out_en;
  logic [42:0] out_msg;
  logic        out_reject = 1'b0;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [42:0] mq [3][$];
  int          rr_m = 0;
  bit          held [3];
  bit          log_en = 1'b0;
  logic [42:0] grant_log [$];
  int          seq = 0;

  always #5 clock = ~clock;

  complete_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .flash                (flash),
    .alu_result_en        (in_en[0]),
    .alu_result_msg       (in_msg[0]),
    .alu_result_reject    (rej[0]),
    .bru_result_en        (in_en[1]),
    .bru_result_msg       (in_msg[1]),
    .bru_result_reject    (rej[1]),
    .mem_result_en        (in_en[2]),
    .mem_result_msg       (in_msg[2]),
    .mem_result_reject    (rej[2]),
    .complete_info_en     (out_en),
    .complete_info_msg    (out_msg),
    .complete_info_reject (out_reject),
    .busy                 (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < 3; k++) begin
      int c = (rr_m + k) % 3;
      if (mq[c].size() != 0) return c;
    end
    return -1;
  endfunction

  function automatic logic [42:0] wb_msg(input logic [7:0] id, input logic [31:0] data);
    return {id, 1'b0, 2'b00, data};
  endfunction

  function automatic logic [42:0] br_msg(input logic [7:0] id, input logic miss,
                                         input logic taken, input logic [31:0] pc);
    return {id, 1'b1, miss, taken, pc};
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      mq[ch].delete();
      held[ch] = 1'b0;
    end
    rr_m = 0;
  endtask

  // New offers only on channels whose previous offer was not rejected.
  task automatic offer_random(input int pct);
    logic [31:0] r0;
    logic [31:0] r1;
    for (int ch = 0; ch < 3; ch++) begin
      if (!held[ch]) begin
        r0 = $urandom;
        r1 = $urandom;
        seq++;
        in_en[ch]  = ($urandom_range(99) < pct);
        in_msg[ch] = {2'(ch), 6'(seq), (ch == 1), (ch == 1) ? r1[1:0] : 2'b00, r0};
      end
    end
  endtask

  task automatic drop_all();
    for (int ch = 0; ch < 3; ch++) begin
      in_en[ch] = 1'b0;
      held[ch]  = 1'b0;
    end
  endtask

  // One clock cycle: compare outputs mid-cycle, advance the model, return at posedge+1.
  task automatic step();
    int g;
    bit any;
    bit full_m [3];
    @(negedge clock);
    g = pick();
    check_eq("en", 64'(out_en), 64'(g >= 0));
    if (g >= 0) check_eq("msg", 64'(out_msg), 64'(mq[g][0]));
    any = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      full_m[ch] = (mq[ch].size() == DEPTH);
      check_eq($sformatf("reject%0d", ch), 64'(rej[ch]), 64'(full_m[ch]));
      any = any | (mq[ch].size() != 0);
      held[ch] = in_en[ch] && full_m[ch];
    end
    check_eq("busy", 64'(busy), 64'(any));
    if (out_en && !out_reject) begin
      $display("xfer t=%0t id=%02h kind=%0d content=%09h%s", $time, out_msg[42:35],
               out_msg[34], out_msg[33:0], flash ? " flash" : "");
      if (log_en) grant_log.push_back(out_msg);
    end
    if (flash) begin
      for (int ch = 0; ch < 3; ch++) mq[ch].delete();
      rr_m = 0;
    end else begin
      if (g >= 0 && !out_reject) begin
        void'(mq[g].pop_front());
        rr_m = (g + 1) % 3;
      end
      for (int ch = 0; ch < 3; ch++) begin
        if (in_en[ch] && !full_m[ch]) mq[ch].push_back(in_msg[ch]);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_en"}, 64'(out_en), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    for (int ch = 0; ch < 3; ch++) begin
      check_eq($sformatf("%s_rej%0d", tag, ch), 64'(rej[ch]), 64'(0));
    end
  endtask

  initial begin
    int cnt [3];
    for (int ch = 0; ch < 3; ch++) begin
      in_en[ch]  = 1'b0;
      in_msg[ch] = '0;
    end
    model_reset();

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check_idle("rst");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Single result: accepted in cycle 1, presented in cycle 2, idle in cycle 3
    in_en[0]  = 1'b1;
    in_msg[0] = wb_msg(8'd5, 32'h1234);
    step();
    in_en[0] = 1'b0;
    check_eq("single_en", 64'(out_en), 64'(1));
    check_eq("single_id", 64'(out_msg[42:35]), 64'(5));
    check_eq("single_kind", 64'(out_msg[34]), 64'(0));
    check_eq("single_data", 64'(out_msg[31:0]), 64'(32'h1234));
    step();
    check_eq("single_busy", 64'(busy), 64'(0));
    step();

    // Fairness: every channel pushing every cycle
    flash = 1'b1;
    step();
    flash = 1'b0;
    log_en = 1'b1;
    repeat (30) begin
      offer_random(100);
      step();
    end
    log_en = 1'b0;
    drop_all();
    repeat (6) step();
    check_eq("rr_grants", 64'(grant_log.size() >= 27), 64'(1));
    for (int ch = 0; ch < 3; ch++) cnt[ch] = 0;
    for (int i = 0; i < grant_log.size(); i++) begin
      check_eq($sformatf("rr_seq%0d", i), 64'(grant_log[i][42:41]), 64'(i % 3));
      if (i < 27) cnt[grant_log[i][42:41]]++;
    end
    for (int ch = 0; ch < 3; ch++) check_eq($sformatf("rr_share%0d", ch), 64'(cnt[ch]), 64'(9));

    // Backpressure and full-with-pop on ALU
    out_reject = 1'b1;
    in_en[0]   = 1'b1;
    in_msg[0]  = wb_msg(8'h01, 32'hA1);
    step();
    in_msg[0] = wb_msg(8'h02, 32'hA2);
    step();
    in_msg[0] = wb_msg(8'h03, 32'hA3);
    check_eq("bp_reject", 64'(rej[0]), 64'(1));
    check_eq("bp_head", 64'(out_msg[42:35]), 64'(1));
    step();
    check_eq("bp_stable", 64'(out_msg[42:35]), 64'(1));
    out_reject = 1'b0;
    check_eq("fp_full", 64'(rej[0]), 64'(1));
    step();
    check_eq("fp_reject", 64'(rej[0]), 64'(0));
    check_eq("fp_head", 64'(out_msg[42:35]), 64'(2));
    step();
    in_en[0] = 1'b0;
    check_eq("fp_third", 64'(out_msg[42:35]), 64'(3));
    repeat (3) step();

    // Flash with two BRU entries buffered; rr_ptr is 1 beforehand
    out_reject = 1'b1;
    in_en[1]   = 1'b1;
    in_msg[1]  = br_msg(8'h10, 1'b1, 1'b0, 32'h40);
    step();
    in_msg[1] = br_msg(8'h11, 1'b1, 1'b0, 32'h40);
    step();
    in_en[1] = 1'b0;
    check_eq("fl_busy_before", 64'(busy), 64'(1));
    check_eq("fl_bru_full", 64'(rej[1]), 64'(1));
    check_eq("fl_bru_pc", 64'(out_msg[31:0]), 64'(32'h40));
    flash = 1'b1;
    step();
    flash      = 1'b0;
    out_reject = 1'b0;
    check_idle("fl");
    for (int ch = 0; ch < 3; ch++) begin
      in_en[ch]  = 1'b1;
      in_msg[ch] = wb_msg({2'(ch), 6'h3F}, 32'(ch));
    end
    step();
    drop_all();
    check_eq("fl_rr_zero", 64'(out_msg[42:41]), 64'(0));
    repeat (4) step();

    // Asynchronous reset mid-cycle with entries buffered
    out_reject = 1'b1;
    in_en[0]   = 1'b1;
    in_msg[0]  = wb_msg(8'h21, 32'hB0);
    in_en[2]   = 1'b1;
    in_msg[2]  = wb_msg(8'h22, 32'hB1);
    step();
    drop_all();
    check_eq("ar_busy_before", 64'(busy), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("ar");
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset_n    = 1'b1;
    out_reject = 1'b0;
    @(posedge clock);
    #1;
    repeat (3) step();

    // Randomized traffic with backpressure and occasional flash
    repeat (400) begin
      out_reject = ($urandom_range(99) < 30);
      flash      = ($urandom_range(99) < 3);
      offer_random(60);
      step();
    end
    flash      = 1'b0;
    out_reject = 1'b0;
    drop_all();
    repeat (8) step();
    check_idle("end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/complete_arbiter.md
COMPLETE_ARBITER -- requirements
Module: complete_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, entries per input channel skid FIFO (legal 2..4).
REQ-002 Parameter: N_CH, fixed 3, number of execution-unit result channels (0 = ALU, 1 = BRU, 2 = MEM).
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 flash  input  1  synchronous pipeline flush; discards all buffered results.
REQ-006 alu_result  Message.receiver  CompleteInfo  ALU results: en, msg, reject.
REQ-007 bru_result  Message.receiver  CompleteInfo  branch-unit results: en, msg, reject.
REQ-008 mem_result  Message.receiver  CompleteInfo  load/store-unit results: en, msg, reject.
REQ-009 complete_info  Message.sender  CompleteInfo  one completion per cycle to the commit queue.
REQ-010 busy  output  1  high while any channel FIFO holds an entry.
REQ-011 CompleteInfo fields: commit_id w8; kind 1 (1 = branch, 0 = writeback); content.branch {miss 1, taken 1, new_pc 32}; content.wb {data 32}.

Function
REQ-012 A transfer on any Message link SHALL occur in a cycle with en=1 and reject=0; the sender holds en and msg stable while reject=1.
REQ-013 Each channel SHALL own a FIFO of FIFO_DEPTH CompleteInfo entries with a wrap-around read pointer, write pointer, and count.
REQ-014 Channel reject SHALL be registered-state only: reject = (count == FIFO_DEPTH); no combinational path from complete_info.reject to any input reject.
REQ-015 A full FIFO SHALL reject a push even when a pop occurs in the same cycle.
REQ-016 A push into a non-full FIFO SHALL be accepted while a same-cycle pop occurs; count is unchanged.
REQ-017 Push alone increments count; pop alone decrements count; pointers wrap modulo FIFO_DEPTH.
REQ-018 complete_info.en = any channel non-empty; complete_info.msg = head of the granted channel (combinational from FIFO state).
REQ-019 Grant SHALL be round-robin: search starts at rr_ptr and takes the first non-empty channel in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
REQ-020 On a completed output transfer (en & ~reject), the granted FIFO pops and rr_ptr becomes (granted + 1) mod 3; otherwise rr_ptr holds.
REQ-021 While complete_info.reject=1, grant and msg SHALL stay stable (rr_ptr frozen) and no FIFO pops.
REQ-022 Minimum latency: a result accepted in cycle N is presented on complete_info in cycle N+1; no same-cycle bypass.
REQ-023 Per-channel order SHALL be preserved; no cross-channel ordering is guaranteed.
REQ-024 No message field is modified; kind and content pass through bit-exact.
REQ-025 When flash=1 in cycle N: all counts and pointers are cleared and rr_ptr is set to 0 at the edge ending N; inputs offered in N are discarded; complete_info.en=0 from N+1.
REQ-026 flash takes priority over simultaneous push and pop; an output transfer in cycle N is still considered sent by the receiver.
REQ-027 busy = OR of (count != 0) over all channels.

Reset
REQ-028 reset_n=0 SHALL immediately and asynchronously clear all counts, pointers, and rr_ptr; FIFO data is don't-care.
REQ-029 During reset and the first cycle after it: complete_info.en=0, all input rejects=0, busy=0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered entries; nothing is replayed after release.

Verification
REQ-031 Single result: ALU push id=5, data=0x1234 in cycle 1 -> complete_info en=1, id=5, kind=0, data=0x1234 in cycle 2; busy=0 in cycle 3.
REQ-032 Fairness: all three channels push every cycle with reject=0 -> output channel sequence ALU, BRU, MEM, ALU, ...; each channel gets exactly 1/3 of the grants.
REQ-033 Backpressure: hold complete_info.reject=1 and push 3 to ALU -> first 2 accepted, third sees reject=1; msg stable; release -> ids out in push order.
REQ-034 Full with pop: ALU FIFO full, pop and push in the same cycle -> push rejected, count becomes 1; next-cycle push accepted.
REQ-035 Flash: 2 BRU entries buffered (new_pc=0x40, miss=1), pulse flash -> en=0 next cycle, busy=0, rr_ptr=0, BRU reject=0.
REQ-036 Async reset: assert reset_n low mid-cycle with entries buffered -> en and busy drop before the next edge; post-release output stays idle.
